// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle signed multiply/divide responder for the MIPS datapath.
//   A request is accepted only in IDLE. Multiply uses radix-2 Booth and
//   divide uses restoring division on magnitudes. Each takes WIDTH
//   iterations, then one FIN cycle pulses done with the 64-bit result
//   held on hi_out/lo_out.
//
//   Handshake: start is a strobe that is honoured only while busy is low.
//   When start is accepted, op/a_in/b_in are captured on that edge.
//   done is a single-cycle "result valid" pulse, and no ready/ack is expected.
//   Results stay on hi_out/lo_out until the next completed operation or
//   until reset.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start, op        request strobe, 0 = signed mult, 1 = signed div
//   a_in, b_in       rs / rt operands
//   busy             high whenever state != IDLE
//   done, div_zero   result-valid pulse, divide-by-zero pulse (with done)
//   hi_out, lo_out   mult: product hi/lo, div: remainder/quotient
//   state_dbg        current FSM state (debug visibility)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    // Shared working registers.
    //   mult: {p_hi, p_lo, q_m1} is the Booth accumulator, m is the multiplicand.
    //   div:  p_hi is the partial remainder, p_lo shifts dividend out and
    //         quotient in, m is the divisor magnitude.
    logic [WIDTH-1:0] p_hi, p_lo, m;
    logic             q_m1;
    logic             zflag, neg_q, neg_r;

    logic             last;
    logic [WIDTH:0]   ext_hi, ext_m, booth_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] a_mag, b_mag, q_res, r_res;

    assign last = (cnt == CW'(WIDTH));

    // Booth step on a WIDTH+1 bit sign-extended high half, so subtracting
    // the most negative multiplicand cannot overflow before the shift.
    always_comb begin
        ext_hi    = {p_hi[WIDTH-1], p_hi};
        ext_m     = {m[WIDTH-1], m};
        booth_sum = ext_hi;
        case ({p_lo[0], q_m1})
            2'b01:   booth_sum = ext_hi + ext_m;
            2'b10:   booth_sum = ext_hi - ext_m;
            default: booth_sum = ext_hi;
        endcase
    end

    // Restoring division step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m};
        div_fits  = ~div_diff[WIDTH];
    end

    // Magnitudes are plain two's complement negation. The most negative value
    // keeps its bit pattern, which is the right unsigned magnitude.
    always_comb begin
        a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
        b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
        q_res = neg_q ? (~p_lo + 1'b1) : p_lo;
        r_res = neg_r ? (~p_hi + 1'b1) : p_hi;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = op ? DIV : MULT;
            MULT: if (last) state_next = FIN;
            DIV:  if (last) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            m      <= '0;
            q_m1   <= 1'b0;
            zflag  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        zflag <= 1'b0;
                        q_m1  <= 1'b0;
                        p_hi  <= '0;
                        if (!op) begin
                            p_lo <= b_in;
                            m    <= a_in;
                        end else begin
                            p_lo  <= a_mag;
                            m     <= b_mag;
                            neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            neg_r <= a_in[WIDTH-1];
                            // Zero divisor skips all iterations, so FIN
                            // follows on the next edge.
                            if (b_in == '0) begin
                                zflag <= 1'b1;
                                cnt   <= CW'(WIDTH);
                            end
                        end
                    end
                end
                MULT: begin
                    if (last) begin
                        hi_out <= p_hi;
                        lo_out <= p_lo;
                    end else begin
                        p_hi <= booth_sum[WIDTH:1];
                        p_lo <= {booth_sum[0], p_lo[WIDTH-1:1]};
                        q_m1 <= p_lo[0];
                        cnt  <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (last) begin
                        if (!zflag) begin
                            hi_out <= r_res;
                            lo_out <= q_res;
                        end
                    end else begin
                        p_hi <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        p_lo <= {p_lo[WIDTH-2:0], div_fits};
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign div_zero  = (state == FIN) && zflag;
    assign state_dbg = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases with literal results plus
// randomized operations compared every cycle against a behavioural model
// built from plain signed arithmetic and a completion countdown.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;
  logic [1:0]   state_dbg;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {div_zero, hi, lo} from plain signed arithmetic.
  function automatic logic [2*W:0] model_result(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] pv, qv, rv;
    sa = $signed(a);
    sb = $signed(b);
    if (!o) begin
      p  = sa * sb;
      pv = p;
      return {1'b0, pv};
    end else if (b == '0) begin
      return {1'b1, 64'h0};
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {1'b0, rv[31:0], qv[31:0]};
    end
  endfunction

  // Behavioural model: accepted requests queue their result, which appears
  // after a fixed number of edges (W+1 normally, 1 for divide by zero).
  logic [2*W:0] exp_q[$];
  logic [2*W:0] res;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
      exp_q.delete();
    end else if (m_done) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        res    = exp_q.pop_front();
        m_done = 1'b1;
        m_dz   = res[2*W];
        if (!res[2*W]) begin
          m_hi = res[2*W-1:W];
          m_lo = res[W-1:0];
        end
      end
    end else if (start) begin
      exp_q.push_back(model_result(op, a_in, b_in));
      m_busy = 1'b1;
      m_left = (op && b_in == '0) ? 1 : W + 1;
    end
  end

  // Compare process: every cycle once the bench is armed.
  logic armed = 1'b0;
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("hi_out", hi_out, m_hi);
      chk("lo_out", lo_out, m_lo);
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    // Operand changes after acceptance must have no effect.
    a_in = $urandom; b_in = $urandom; op = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int cyc, input bit noise);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!done && noise) begin
        start = ($urandom_range(0, 7) == 0);
        a_in  = $urandom; b_in = $urandom; op = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    chk("done_timeout", done, 1'b1);
  endtask

  function automatic logic [W-1:0] pick_operand(input bit allow_zero);
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return allow_zero ? 32'h0 : 32'h1;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, cnt_done;
    logic o;
    logic [W-1:0] a, b;

    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_hi", hi_out, 32'h0);
    chk("reset_lo", lo_out, 32'h0);

    // 1: 7 * -3
    issue(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    wait_done(cyc, 1'b0);
    chk("t1_latency", 32'(cyc), 32'd33);
    chk("t1_hi", hi_out, 32'hFFFF_FFFF);
    chk("t1_lo", lo_out, 32'hFFFF_FFEB);
    chk("t1_model_lo", m_lo, 32'hFFFF_FFEB);

    // 2: most negative squared
    issue(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc, 1'b0);
    chk("t2_hi", hi_out, 32'h4000_0000);
    chk("t2_lo", lo_out, 32'h0000_0000);
    chk("t2_dz", div_zero, 1'b0);
    chk("t2_model_hi", m_hi, 32'h4000_0000);

    // 3: -7 / 2
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(cyc, 1'b0);
    chk("t3_lo", lo_out, 32'hFFFF_FFFD);
    chk("t3_hi", hi_out, 32'hFFFF_FFFF);
    chk("t3_model_hi", m_hi, 32'hFFFF_FFFF);

    // 4: overflow divide
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, 1'b0);
    chk("t4_lo", lo_out, 32'h8000_0000);
    chk("t4_hi", hi_out, 32'h0000_0000);
    chk("t4_dz", div_zero, 1'b0);
    chk("t4_model_lo", m_lo, 32'h8000_0000);

    // 5: divide by zero keeps previous result
    issue(1'b1, 32'h0000_0005, 32'h0000_0000);
    wait_done(cyc, 1'b0);
    chk("t5_latency", 32'(cyc), 32'd1);
    chk("t5_dz", div_zero, 1'b1);
    chk("t5_hi", hi_out, 32'h0000_0000);
    chk("t5_lo", lo_out, 32'h8000_0000);

    // 6: start while busy ignored, reset aborts run
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", busy, 1'b0);
    chk("t6_hi", hi_out, 32'h0);
    chk("t6_lo", lo_out, 32'h0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    chk("t6_no_done", 32'(cnt_done), 32'd0);

    // randomized operations
    for (int i = 0; i < 200; i++) begin
      o = 1'($urandom_range(0, 1));
      a = pick_operand(1'b1);
      b = pick_operand(1'b1);
      issue(o, a, b);
      wait_done(cyc, 1'b1);
      chk("rand_latency", 32'(cyc), (o && b == '0) ? 32'd1 : 32'd33);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
